// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   mul_op_t       : operation code issued by EX (also used by the decoder)
//   muldiv_state_t : sequencer FSM state, exported for debug visibility
//   DIV_ITERS      : radix-2 divide iterations (one quotient bit per edge)
//   MUL_LATENCY_MAX: upper bound on the multiplier latency parameter
package muldiv_pkg;

  localparam int DIV_ITERS       = 32;
  localparam int MUL_LATENCY_MAX = 8;

  typedef enum logic [3:0] {
    OP_DISABLED = 4'd0,
    OP_MULT     = 4'd1,
    OP_MULTU    = 4'd2,
    OP_DIV      = 4'd3,
    OP_DIVU     = 4'd4,
    OP_MADD     = 4'd5,
    OP_MADDU    = 4'd6,
    OP_MSUB     = 4'd7,
    OP_SETHI    = 4'd8,
    OP_SETLO    = 4'd9
  } mul_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV     = 2'd2,
    ST_DIV_FIX = 2'd3
  } muldiv_state_t;

  function automatic logic op_is_div(input mul_op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider working on operand magnitudes.
//   clk, reset      : clock, async active-high reset
//   load            : capture operands and start a new divide
//   step            : perform one iteration (one quotient bit)
//   signed_op       : operands are two's complement (DIV) rather than DIVU
//   dividend/divisor: operands, sampled on load
//   last            : the current step is the final iteration
//   quotient/remainder: sign-corrected results, valid after the last step
// Divide-by-zero returns quotient all ones and remainder = dividend.
// The signed overflow case 0x80000000 / -1 returns 0x80000000 rem 0.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic [31:0] rem_q, quo_q, dvs_q, dividend_q;
  logic        neg_quo_q, neg_rem_q, zero_q, ovf_q;
  logic [4:0]  iter_q;

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] shifted, diff;
  logic        fits;

  assign a_neg = signed_op & dividend[31];
  assign b_neg = signed_op & divisor[31];
  assign mag_a = a_neg ? (32'd0 - dividend) : dividend;
  assign mag_b = b_neg ? (32'd0 - divisor)  : divisor;

  // quo_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[32];
  assign last    = (iter_q == LAST_ITER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      iter_q     <= '0;
    end else if (load) begin
      rem_q      <= '0;
      quo_q      <= mag_a;
      dvs_q      <= mag_b;
      dividend_q <= dividend;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      zero_q     <= (divisor == 32'd0);
      ovf_q      <= signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
      iter_q     <= '0;
    end else if (step) begin
      quo_q  <= {quo_q[30:0], fits};
      rem_q  <= fits ? diff[31:0] : shifted[31:0];
      iter_q <= iter_q + 5'd1;
    end
  end

  always_comb begin
    quotient  = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    remainder = neg_rem_q ? (32'd0 - rem_q) : rem_q;
    if (zero_q) begin
      quotient  = 32'hFFFF_FFFF;
      remainder = dividend_q;
    end else if (ovf_q) begin
      quotient  = 32'h8000_0000;
      remainder = 32'd0;
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// HI/LO multiply/divide sequencer for the EX stage.
//   clk, reset     : clock, async active-high reset
//   start, op      : issue strobe and operation; sampled when idle and not flushed
//   src_a, src_b   : rs / rt operands
//   flush          : kills the in-flight operation (and blocks a same-cycle issue)
//   busy           : operation in flight; stalls MFHI/MFLO and new issues
//   done           : one-cycle pulse in the cycle after a multi-cycle HI/LO write
//   hi, lo         : architectural HI/LO registers
//   fsm_state      : current sequencer state, for debug
// Build option: define MULDIV_ACC_EN to enable MADD/MADDU/MSUB accumulate;
// without it those opcodes are ignored like OP_DISABLED.
// Handshake: an issue is accepted on a rising edge where start=1, busy=0,
// flush=0 and op decodes to a supported operation; there is no backpressure
// other than busy, and a start seen while busy is dropped, not queued.
// MUL_LATENCY must be in 1..MUL_LATENCY_MAX.
module mul_div_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  mul_op_t       op,
  input  logic [31:0]   src_a,
  input  logic [31:0]   src_b,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [31:0]   hi,
  output logic [31:0]   lo,
  output muldiv_state_t fsm_state
);

  localparam int               CNT_W    = $clog2(MUL_LATENCY_MAX);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

  muldiv_state_t    state, next_state;
  logic [31:0]      a_q, b_q;
  mul_op_t          op_q;
  logic [CNT_W-1:0] mul_cnt;

  logic        is_mul_op, op_valid, accept;
  logic        mul_signed;
  logic [63:0] ext_a, ext_b, product, mul_result;
  logic        div_last;
  logic [31:0] div_quo, div_rem;
  logic        hi_we, lo_we, done_d;
  logic [31:0] hi_d, lo_d;

  // Opcode decode: anything not listed behaves as OP_DISABLED.
  always_comb begin
    is_mul_op = 1'b0;
    op_valid  = 1'b1;
    case (op)
      OP_MULT, OP_MULTU: is_mul_op = 1'b1;
`ifdef MULDIV_ACC_EN
      OP_MADD, OP_MADDU, OP_MSUB: is_mul_op = 1'b1;
`endif
      OP_DIV, OP_DIVU, OP_SETHI, OP_SETLO: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;
  assign accept    = start && !busy && !flush && op_valid;

  // Sign-extending to 64 bits and keeping the low 64 bits of the product
  // gives the signed result mod 2^64 from a single multiplier.
  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign ext_a      = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b      = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product    = ext_a * ext_b;

`ifdef MULDIV_ACC_EN
  always_comb begin
    case (op_q)
      OP_MADD, OP_MADDU: mul_result = {hi, lo} + product;
      OP_MSUB:           mul_result = {hi, lo} - product;
      default:           mul_result = product;
    endcase
  end
`else
  assign mul_result = product;
`endif

  muldiv_div_core u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept && op_is_div(op)),
    .step      (state == ST_DIV),
    .signed_op (op == OP_DIV),
    .dividend  (src_a),
    .divisor   (src_b),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next state and HI/LO write enables. A flush in any busy state wins
  // over the write scheduled for that same edge.
  always_comb begin
    next_state = state;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = hi;
    lo_d       = lo;
    done_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_SETHI) begin
            hi_we = 1'b1;
            hi_d  = src_a;
          end else if (op == OP_SETLO) begin
            lo_we = 1'b1;
            lo_d  = src_a;
          end else if (op_is_div(op)) begin
            next_state = ST_DIV;
          end else if (is_mul_op) begin
            next_state = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          next_state = ST_IDLE;
        end else if (mul_cnt == MUL_LAST) begin
          next_state = ST_IDLE;
          hi_we      = 1'b1;
          lo_we      = 1'b1;
          hi_d       = mul_result[63:32];
          lo_d       = mul_result[31:0];
          done_d     = 1'b1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          next_state = ST_IDLE;
        end else if (div_last) begin
          next_state = ST_DIV_FIX;
        end
      end
      ST_DIV_FIX: begin
        next_state = ST_IDLE;
        if (!flush) begin
          hi_we  = 1'b1;
          lo_we  = 1'b1;
          hi_d   = div_rem;
          lo_d   = div_quo;
          done_d = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_DISABLED;
      mul_cnt <= '0;
    end else begin
      state <= next_state;
      done  <= done_d;
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
      if (accept && is_mul_op) begin
        a_q     <= src_a;
        b_q     <= src_b;
        op_q    <= op;
        mul_cnt <= '0;
      end else if (state == ST_MUL) begin
        mul_cnt <= mul_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: directed cases, flush and reset
// corner cases, then randomized operations against an arithmetic model.
// Honours MULDIV_ACC_EN the same way as the design build.
module tb_mul_div_sequencer;
  import muldiv_pkg::*;

  localparam int LAT     = 3;
  localparam int DIV_LAT = 33;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  mul_op_t       op;
  logic [31:0]   src_a, src_b;
  logic          flush;
  logic          busy, done;
  logic [31:0]   hi, lo;
  muldiv_state_t fsm_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_hilo = '0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mul_div_sequencer #(.MUL_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic int model_latency(input mul_op_t o);
    case (o)
      OP_MULT, OP_MULTU: return LAT;
`ifdef MULDIV_ACC_EN
      OP_MADD, OP_MADDU, OP_MSUB: return LAT;
`endif
      OP_DIV, OP_DIVU: return DIV_LAT;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_result(input mul_op_t o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, sprod, uprod, q, r;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ua    = {32'd0, a};
    ub    = {32'd0, b};
    sprod = sa * sb;
    uprod = ua * ub;
    case (o)
      OP_SETHI: return {a, cur[31:0]};
      OP_SETLO: return {cur[63:32], a};
      OP_MULT:  return sprod;
      OP_MULTU: return uprod;
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          q  = sq;
          r  = sr;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        return {r[31:0], q[31:0]};
      end
`ifdef MULDIV_ACC_EN
      OP_MADD:  return cur + sprod;
      OP_MADDU: return cur + uprod;
      OP_MSUB:  return cur - sprod;
`endif
      default:  return cur;
    endcase
  endfunction

  // driver: issue one op, follow it to completion, score the result
  task automatic run_op(input mul_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int lat;
    int edges;
    lat = model_latency(o);
    exp_q.push_back(model_result(o, a, b, model_hilo));
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    if (lat == 0) begin
      check({tag, " busy"}, {63'd0, busy}, 64'd0);
      check({tag, " done"}, {63'd0, done}, 64'd0);
    end else begin
      edges = 0;
      while (busy === 1'b1 && edges < 100) begin
        tick();
        edges++;
      end
      check({tag, " latency"}, 64'(edges), 64'(lat));
      check({tag, " done"}, {63'd0, done}, 64'd1);
    end
    model_hilo = exp_q.pop_front();
    check({tag, " hilo"}, {hi, lo}, model_hilo);
    if (lat > 0) begin
      tick();
      check({tag, " done_clear"}, {63'd0, done}, 64'd0);
    end
  endtask

  initial begin
    mul_op_t     rop;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = OP_DISABLED;
    src_a = '0;
    src_b = '0;
    #2;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset state", 64'(fsm_state), 64'(ST_IDLE));
    #10;
    reset = 1'b0;
    tick();

    // directed cases
    run_op(OP_SETHI, 32'h1, 32'h0, "sethi");
    run_op(OP_SETLO, 32'h2, 32'h0, "setlo");
    run_op(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu");
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, "mult_neg");
    check("mult_neg value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    check("divu_100_7 value", {hi, lo}, {32'd2, 32'd14});
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    check("div_neg7_2 value", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(OP_DIV, 32'd5, 32'd0, "div_by_zero");
    run_op(OP_DIVU, 32'hF000_0001, 32'd0, "divu_by_zero");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf value", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(OP_DISABLED, 32'h1234, 32'h5678, "disabled");
    run_op(OP_MSUB, 32'd9, 32'hFFFF_FFFE, "msub");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");

    // flush mid-divide, with a start held high the whole time
    run_op(OP_SETHI, 32'h1111_2222, 32'h0, "pre_flush_hi");
    op    = OP_DIV;
    src_a = 32'd1000;
    src_b = 32'd3;
    start = 1'b1;
    tick();
    op    = OP_SETHI;
    src_a = 32'hDEAD_BEEF;
    repeat (10) tick();
    check("flush pre busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    check("flush busy", {63'd0, busy}, 64'd0);
    check("flush done", {63'd0, done}, 64'd0);
    check("flush hilo", {hi, lo}, model_hilo);
    tick();
    check("flush blocks start", {hi, lo}, model_hilo);
    check("flush blocks busy", {63'd0, busy}, 64'd0);
    flush = 1'b0;
    start = 1'b0;
    tick();
    check("flush no done", {63'd0, done}, 64'd0);

    // flush on the same edge as the multiply write
    op    = OP_MULT;
    src_a = 32'd5;
    src_b = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT - 1) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_wr busy", {63'd0, busy}, 64'd0);
    check("flush_wr done", {63'd0, done}, 64'd0);
    check("flush_wr hilo", {hi, lo}, model_hilo);
    tick();
    check("flush_wr done_late", {63'd0, done}, 64'd0);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      rop = mul_op_t'($urandom_range(0, 9));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
        3: rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    // reset in the middle of a divide
    run_op(OP_SETLO, 32'hA5A5_A5A5, 32'h0, "pre_reset_lo");
    op    = OP_DIVU;
    src_a = 32'd12345;
    src_b = 32'd17;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset done", {63'd0, done}, 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    check("midreset state", 64'(fsm_state), 64'(ST_IDLE));
    #2;
    reset      = 1'b0;
    model_hilo = '0;
    tick();
    run_op(OP_DIVU, 32'd12345, 32'd17, "post_reset_divu");
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, "post_reset_mult");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
